// File: rtl/bcd_display_formatter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_display_formatter
//  Purpose  : Sequential double-dabble binary-to-BCD converter feeding a
//             4-digit seven-segment scan driver. One bit is converted per
//             clock behind a valid/ready handshake. The output registers hold
//             the last committed value, so the display never shows a partial
//             result. Values above MAX_VALUE are shown as "EEEE" with every
//             decimal point lit.
//  Ports    : clk, rst_n       - clock, asynchronous active-low reset
//             i_valid/o_ready  - request handshake (o_ready = idle)
//             i_bin, i_dots    - value and dot mask, sampled at accept
//             o_data, o_dots   - committed packed BCD {d3,d2,d1,d0} and dots
//             o_ovf            - last committed value was over-range
//             o_done           - one-cycle pulse following each commit
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_display_formatter #(
    parameter int          IN_WIDTH  = 16,
    parameter int unsigned MAX_VALUE = 9999
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [IN_WIDTH-1:0] i_bin,
    input  logic [3:0]          i_dots,
    output logic [15:0]         o_data,
    output logic [3:0]          o_dots,
    output logic                o_ovf,
    output logic                o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [4:0]  c_LAST    = 5'(IN_WIDTH - 1);
    localparam logic [15:0] c_ERR_BCD = 16'hEEEE;

    state_t                r_state_q, w_state_d;
    logic [IN_WIDTH-1:0]   r_bin_q,   w_bin_d;
    logic [15:0]           r_bcd_q,   w_bcd_d;
    logic [4:0]            r_cnt_q,   w_cnt_d;
    logic [3:0]            r_pdots_q, w_pdots_d;
    logic [15:0]           r_data_q,  w_data_d;
    logic [3:0]            r_dots_q,  w_dots_d;
    logic                  r_ovf_q,   w_ovf_d;
    logic                  r_done_q,  w_done_d;

    logic                  w_over;
    logic [14:0]           w_bcd_corr;
    logic [15:0]           w_bcd_shift;
    logic [IN_WIDTH-1:0]   w_bin_shift;

    // Zero-extend to 32 bits so a MAX_VALUE wider than the input simply
    // makes the over-range branch unreachable.
    assign w_over = ({{(32-IN_WIDTH){1'b0}}, i_bin} > MAX_VALUE);

    // Add-3 correction on the lower three digits.
    generate
        for (genvar g = 0; g < 3; g++) begin : g_nibble
            assign w_bcd_corr[4*g+3:4*g] = (r_bcd_q[4*g+3:4*g] >= 4'd5) ?
                                           r_bcd_q[4*g+3:4*g] + 4'd3 :
                                           r_bcd_q[4*g+3:4*g];
        end
    endgenerate

    // The top digit stays <= 9 for in-range values, so only its low three
    // corrected bits survive the following shift.
    assign w_bcd_corr[14:12] = 3'((r_bcd_q[15:12] >= 4'd5) ?
                                  r_bcd_q[15:12] + 4'd3 : r_bcd_q[15:12]);

    assign w_bcd_shift = {w_bcd_corr, r_bin_q[IN_WIDTH-1]};
    assign w_bin_shift = {r_bin_q[IN_WIDTH-2:0], 1'b0};

    always_comb begin
        w_state_d = r_state_q;
        w_bin_d   = r_bin_q;
        w_bcd_d   = r_bcd_q;
        w_cnt_d   = r_cnt_q;
        w_pdots_d = r_pdots_q;
        w_data_d  = r_data_q;
        w_dots_d  = r_dots_q;
        w_ovf_d   = r_ovf_q;
        w_done_d  = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (i_valid) begin
                    if (w_over) begin
                        w_data_d  = c_ERR_BCD;
                        w_dots_d  = 4'hF;
                        w_ovf_d   = 1'b1;
                        w_done_d  = 1'b1;
                        w_state_d = S_DONE;
                    end else begin
                        w_bin_d   = i_bin;
                        w_bcd_d   = 16'h0000;
                        w_pdots_d = i_dots;
                        w_cnt_d   = 5'd0;
                        w_state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                w_bin_d = w_bin_shift;
                w_bcd_d = w_bcd_shift;
                w_cnt_d = r_cnt_q + 5'd1;
                if (r_cnt_q == c_LAST) begin
                    // Final iteration goes straight to the display registers.
                    w_data_d  = w_bcd_shift;
                    w_dots_d  = r_pdots_q;
                    w_ovf_d   = 1'b0;
                    w_done_d  = 1'b1;
                    w_state_d = S_DONE;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= S_IDLE;
            r_bin_q   <= '0;
            r_bcd_q   <= 16'h0000;
            r_cnt_q   <= 5'd0;
            r_pdots_q <= 4'h0;
            r_data_q  <= 16'h0000;
            r_dots_q  <= 4'h0;
            r_ovf_q   <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_bin_q   <= w_bin_d;
            r_bcd_q   <= w_bcd_d;
            r_cnt_q   <= w_cnt_d;
            r_pdots_q <= w_pdots_d;
            r_data_q  <= w_data_d;
            r_dots_q  <= w_dots_d;
            r_ovf_q   <= w_ovf_d;
            r_done_q  <= w_done_d;
        end
    end

    assign o_ready = (r_state_q == S_IDLE);
    assign o_data  = r_data_q;
    assign o_dots  = r_dots_q;
    assign o_ovf   = r_ovf_q;
    assign o_done  = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_formatter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_display_formatter
//  Purpose  : Directed self-checking bench for bcd_display_formatter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_display_formatter;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_bin;
    logic [3:0]  i_dots;
    logic [15:0] o_data;
    logic [3:0]  o_dots;
    logic        o_ovf;
    logic        o_done;

    int errors = 0;
    int checks = 0;

    // Bench-side record of what the display should currently be holding.
    logic [15:0] m_data;
    logic [3:0]  m_dots;
    logic        m_ovf;

    bcd_display_formatter #(
        .IN_WIDTH  (16),
        .MAX_VALUE (9999)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_bin   (i_bin),
        .i_dots  (i_dots),
        .o_data  (o_data),
        .o_dots  (o_dots),
        .o_ovf   (o_ovf),
        .o_done  (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_data"},  32'(o_data),  32'(m_data));
        chk({tag, "_dots"},  32'(o_dots),  32'(m_dots));
        chk({tag, "_ovf"},   32'(o_ovf),   32'(m_ovf));
    endtask

    // One full transaction. Inputs are presented in an idle cycle, the accept
    // edge is the next posedge, and everything is sampled 1 time unit after
    // each posedge. With busy_poke set, a different request is held on the
    // inputs for the whole conversion and must be ignored.
    task automatic do_conv(input string tag, input logic [15:0] bin, input logic [3:0] dots,
                           input logic [15:0] ed, input logic [3:0] edots,
                           input logic eovf, input logic busy_poke);
        int lat;
        lat = eovf ? 0 : 16;
        chk({tag, "_ready_pre"}, 32'(o_ready), 32'd1);
        i_valid = 1'b1;
        i_bin   = bin;
        i_dots  = dots;
        @(posedge clk); #1;
        i_valid = busy_poke;
        i_bin   = 16'd1234;
        i_dots  = 4'hA;
        for (int k = 0; k < lat; k++) begin
            chk({tag, "_hold_data"}, 32'(o_data), 32'(m_data));
            chk({tag, "_busy_ready"}, 32'(o_ready), 32'd0);
            chk({tag, "_busy_done"}, 32'(o_done), 32'd0);
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        m_data = ed;
        m_dots = edots;
        m_ovf  = eovf;
        chk_idle_outputs({tag, "_commit"});
        chk({tag, "_done_pulse"}, 32'(o_done), 32'd1);
        chk({tag, "_done_ready"}, 32'(o_ready), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_done_clear"}, 32'(o_done), 32'd0);
        chk({tag, "_ready_post"}, 32'(o_ready), 32'd1);
        chk_idle_outputs({tag, "_held"});
    endtask

    // Bounded wait for the o_done pulse; reports cycles elapsed.
    task automatic wait_done(input string tag, input int bound, output int cycles);
        cycles = 0;
        while (o_done !== 1'b1 && cycles < bound) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (o_done !== 1'b1) chk({tag, "_timeout"}, 32'(o_done), 32'd1);
    endtask

    initial begin
        int gap;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_bin   = 16'd0;
        i_dots  = 4'h0;
        m_data  = 16'h0000;
        m_dots  = 4'h0;
        m_ovf   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        chk_idle_outputs("rst");
        chk("rst_done",  32'(o_done),  32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);

        // Basic conversions and the over-range boundary
        do_conv("c100",   16'd100,   4'b0100, 16'h0100, 4'b0100, 1'b0, 1'b0);
        do_conv("c9999",  16'd9999,  4'b0000, 16'h9999, 4'b0000, 1'b0, 1'b0);
        do_conv("c10000", 16'd10000, 4'b0011, 16'hEEEE, 4'hF,    1'b1, 1'b0);
        do_conv("c0",     16'd0,     4'b0001, 16'h0000, 4'b0001, 1'b0, 1'b0);
        do_conv("c5678",  16'd5678,  4'b1001, 16'h5678, 4'b1001, 1'b0, 1'b0);

        // Requests while busy are ignored; input changes after accept too
        do_conv("ign",    16'd100,   4'b0010, 16'h0100, 4'b0010, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("ign_no_second_done", 32'(o_done), 32'd0);
        chk("ign_still_ready",    32'(o_ready), 32'd1);

        // Reset in the middle of a conversion
        i_valid = 1'b1;
        i_bin   = 16'd4321;
        i_dots  = 4'b1111;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        m_data = 16'h0000;
        m_dots = 4'h0;
        m_ovf  = 1'b0;
        chk_idle_outputs("arst");
        chk("arst_done",  32'(o_done),  32'd0);
        chk("arst_ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            chk("arst_no_done", 32'(o_done), 32'd0);
        end
        chk("arst_ready_post", 32'(o_ready), 32'd1);
        chk_idle_outputs("arst_post");
        do_conv("c4321",  16'd4321,  4'b0001, 16'h4321, 4'b0001, 1'b0, 1'b0);

        // Back-to-back with i_valid held high
        i_valid = 1'b1;
        i_bin   = 16'd1;
        i_dots  = 4'b0000;
        @(posedge clk); #1;
        i_bin   = 16'd65535;
        i_dots  = 4'b0101;
        wait_done("b2b1", 40, gap);
        chk("b2b1_lat", 32'(gap), 32'd16);
        chk("b2b1_data", 32'(o_data), 32'h0001);
        chk("b2b1_ovf",  32'(o_ovf),  32'd0);
        @(posedge clk); #1;
        gap = 1;
        wait_done("b2b2", 40, gap);
        // waited from the DONE cycle: one more edge back to IDLE, then accept
        chk("b2b2_gap", 32'(gap), 32'd1);
        chk("b2b2_data", 32'(o_data), 32'hEEEE);
        chk("b2b2_dots", 32'(o_dots), 32'hF);
        chk("b2b2_ovf",  32'(o_ovf),  32'd1);
        i_bin  = 16'd42;
        i_dots = 4'b1000;
        @(posedge clk); #1;
        wait_done("b2b3", 40, gap);
        chk("b2b3_gap", 32'(gap), 32'd17);
        i_valid = 1'b0;
        chk("b2b3_data", 32'(o_data), 32'h0042);
        chk("b2b3_dots", 32'(o_dots), 32'h8);
        chk("b2b3_ovf",  32'(o_ovf),  32'd0);
        @(posedge clk); #1;
        chk("b2b3_ready", 32'(o_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
